// File: rtl/logic_reduce_acc.sv
// rtl/logic_reduce_acc.sv - packet-wise bitwise reduction accumulator (AND/OR/XOR/NAND)
module logic_reduce_acc #(
   parameter int WIDTH = 2,
   parameter int N     = 3
) (
   input  logic               CLK,
   input  logic               RESETN,
   input  logic [N*WIDTH-1:0] I,
   input  logic [1:0]         MODE,
   input  logic               I_VALID,
   input  logic               I_LAST,
   output logic               I_READY,
   output logic [WIDTH-1:0]   O,
   output logic               O_VALID,
   input  logic               O_READY,
   output logic [7:0]         O_BEATS
);

   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_NAND = 2'b11;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             o_valid_q, o_valid_d;
   logic [7:0]       o_beats_q, o_beats_d;

   logic [WIDTH-1:0] red_and, red_or, red_xor;
   logic [WIDTH-1:0] beat_r, acc_step, acc_new;
   logic [7:0]       cnt_new;
   logic [1:0]       eff_mode;
   logic             accept;

   assign I_READY = !o_valid_q | O_READY;
   assign accept  = I_VALID & I_READY;
   assign O       = o_q;
   assign O_VALID = o_valid_q;
   assign O_BEATS = o_beats_q;

   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      for (int k = 0; k < N; k++) begin
         red_and = red_and & I[k*WIDTH +: WIDTH];
         red_or  = red_or  | I[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ I[k*WIDTH +: WIDTH];
      end
   end

   // The packet's op is taken from MODE only on its first beat; later beats use the held copy.
   always_comb begin
      eff_mode = first_q ? MODE : mode_q;
      case (eff_mode)
         MODE_OR: begin
            beat_r   = red_or;
            acc_step = acc_q | red_or;
         end
         MODE_XOR: begin
            beat_r   = red_xor;
            acc_step = acc_q ^ red_xor;
         end
         default: begin
            beat_r   = red_and;
            acc_step = acc_q & red_and;
         end
      endcase
      acc_new = first_q ? beat_r : acc_step;
      cnt_new = first_q ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
   end

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      mode_d    = mode_q;
      o_d       = o_q;
      o_valid_d = o_valid_q;
      o_beats_d = o_beats_q;

      if (o_valid_q && O_READY) begin
         o_valid_d = 1'b0;
      end

      if (accept) begin
         acc_d   = acc_new;
         cnt_d   = cnt_new;
         mode_d  = eff_mode;
         first_d = 1'b0;
         if (I_LAST) begin
            o_d       = (eff_mode == MODE_NAND) ? ~acc_new : acc_new;
            o_beats_d = cnt_new;
            o_valid_d = 1'b1;
            first_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b1;
         mode_q    <= 2'b00;
         o_q       <= '0;
         o_valid_q <= 1'b0;
         o_beats_q <= '0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         mode_q    <= mode_d;
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         o_beats_q <= o_beats_d;
      end
   end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// tb/tb_logic_reduce_acc.sv - directed self-checking bench for logic_reduce_acc
module tb_logic_reduce_acc;

   logic       clk = 1'b0;
   logic       resetn;
   logic [5:0] i_bus;
   logic [1:0] mode;
   logic       i_valid;
   logic       i_last;
   logic       i_ready;
   logic [1:0] o;
   logic       o_valid;
   logic       o_ready;
   logic [7:0] o_beats;

   int errors = 0;
   int checks = 0;

   logic_reduce_acc #(.WIDTH(2), .N(3)) dut (
      .CLK     (clk),
      .RESETN  (resetn),
      .I       (i_bus),
      .MODE    (mode),
      .I_VALID (i_valid),
      .I_LAST  (i_last),
      .I_READY (i_ready),
      .O       (o),
      .O_VALID (o_valid),
      .O_READY (o_ready),
      .O_BEATS (o_beats)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] pack(input logic [1:0] op0, input logic [1:0] op1,
                                       input logic [1:0] op2);
      return {op2, op1, op0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [1:0] op0, input logic [1:0] op1, input logic [1:0] op2,
                           input logic [1:0] m, input logic last);
      i_bus   = pack(op0, op1, op2);
      mode    = m;
      i_last  = last;
      i_valid = 1'b1;
   endtask

   task automatic idle();
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_bus   = '0;
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      o_ready = 1'b1;
      mode    = 2'b00;
      idle();
      tick();
      tick();
      checks++; if (o !== 2'b00) begin errors++; $display("FAIL reset_o: got %b want 00", o); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      checks++; if (o_beats !== 8'd0) begin errors++; $display("FAIL reset_o_beats: got %0d want 0", o_beats); end
      resetn = 1'b1;
      #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
   endtask

   task automatic test_and_single();
      o_ready = 1'b1;
      set_beat(2'b11, 2'b01, 2'b11, 2'b00, 1'b1);
      tick();
      idle();
      checks++; if (o !== 2'b01) begin errors++; $display("FAIL and1_o: got %b want 01", o); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL and1_o_valid: got %b want 1", o_valid); end
      checks++; if (o_beats !== 8'd1) begin errors++; $display("FAIL and1_o_beats: got %0d want 1", o_beats); end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL and1_clear: got %b want 0", o_valid); end
   endtask

   task automatic test_xor_multi();
      o_ready = 1'b1;
      set_beat(2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL xor_midvalid: got %b want 0", o_valid); end
      set_beat(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
      tick();
      set_beat(2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
      tick();
      idle();
      checks++; if (o !== 2'b10) begin errors++; $display("FAIL xor3_o: got %b want 10", o); end
      checks++; if (o_beats !== 8'd3) begin errors++; $display("FAIL xor3_o_beats: got %0d want 3", o_beats); end
      tick();
   endtask

   task automatic test_nand_mode_switch();
      o_ready = 1'b1;
      set_beat(2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
      tick();
      set_beat(2'b11, 2'b10, 2'b11, 2'b01, 1'b1);
      tick();
      idle();
      checks++; if (o !== 2'b01) begin errors++; $display("FAIL nand_o: got %b want 01", o); end
      checks++; if (o_beats !== 8'd2) begin errors++; $display("FAIL nand_o_beats: got %0d want 2", o_beats); end
      tick();
   endtask

   task automatic test_back_to_back();
      o_ready = 1'b0;
      set_beat(2'b01, 2'b10, 2'b00, 2'b01, 1'b1);
      tick();
      checks++; if (o !== 2'b11 || o_valid !== 1'b1) begin
         errors++; $display("FAIL bp_a: got o=%b v=%b want o=11 v=1", o, o_valid);
      end
      set_beat(2'b11, 2'b11, 2'b10, 2'b00, 1'b1);
      #1;
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_i_ready: got %b want 0", i_ready); end
      tick();
      checks++; if (o !== 2'b11 || o_valid !== 1'b1 || o_beats !== 8'd1) begin
         errors++; $display("FAIL bp_hold: got o=%b v=%b n=%0d want o=11 v=1 n=1", o, o_valid, o_beats);
      end
      o_ready = 1'b1;
      #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", i_ready); end
      tick();
      idle();
      checks++; if (o !== 2'b10 || o_valid !== 1'b1 || o_beats !== 8'd1) begin
         errors++; $display("FAIL bp_b: got o=%b v=%b n=%0d want o=10 v=1 n=1", o, o_valid, o_beats);
      end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b want 0", o_valid); end
   endtask

   task automatic test_reset_mid_packet();
      o_ready = 1'b1;
      set_beat(2'b11, 2'b00, 2'b00, 2'b01, 1'b0);
      tick();
      set_beat(2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      tick();
      idle();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
      set_beat(2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
      tick();
      idle();
      checks++; if (o !== 2'b01 || o_beats !== 8'd1) begin
         errors++; $display("FAIL rstmid_result: got o=%b n=%0d want o=01 n=1", o, o_beats);
      end
      tick();
   endtask

   task automatic test_saturate();
      o_ready = 1'b1;
      for (int b = 0; b < 300; b++) begin
         set_beat(2'b11, 2'b11, 2'b11, 2'b00, (b == 299));
         tick();
         if (b == 298) begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sat_early_valid: got %b want 0", o_valid); end
         end
      end
      idle();
      checks++; if (o !== 2'b11 || o_valid !== 1'b1) begin
         errors++; $display("FAIL sat_o: got o=%b v=%b want o=11 v=1", o, o_valid);
      end
      checks++; if (o_beats !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d want 255", o_beats); end
      tick();
   endtask

   initial begin
      test_reset();
      test_and_single();
      test_xor_multi();
      test_nand_mode_switch();
      test_back_to_back();
      test_reset_mid_packet();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_reduce_acc.md
LOGIC_REDUCE_ACC -- requirements
Module: logic_reduce_acc

Interface
REQ-001 Parameter WIDTH, default 2: bit width of each operand and of the result.
REQ-002 Parameter N, default 3: operands per beat, legal range 2..8.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESETN  in  1  reset, synchronous, active-low.
REQ-005 I  in  N*WIDTH  operand bus; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-006 MODE  in  2  op select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 I_VALID  in  1  input beat valid.
REQ-008 I_LAST  in  1  final beat of a packet; qualified by I_VALID.
REQ-009 I_READY  out  1  block can accept a beat.
REQ-010 O  out  WIDTH  packet result.
REQ-011 O_VALID  out  1  O holds an unconsumed result.
REQ-012 O_READY  in  1  downstream accepts O.
REQ-013 O_BEATS  out  8  beats in the reported packet, saturating.

Function
REQ-014 A beat is accepted in any cycle with I_VALID=1 and I_READY=1; no other cycle changes accumulator state.
REQ-015 Per-beat value R is the bitwise op across all N operands (AND, OR, XOR; NAND mode uses AND).
REQ-016 MODE is sampled on the first beat of a packet and held internally; MODE changes mid-packet are ignored until the next first beat.
REQ-017 First beat of packet: ACC = R, count = 1; later beats: ACC = op(ACC, R), count = min(count+1, 255).
REQ-018 On an accepted beat with I_LAST=1, the next edge loads O with the final value (bitwise inverted for NAND), O_BEATS with the final count, sets O_VALID=1, and re-arms first-beat state.
REQ-019 Latency: O_VALID rises on the edge that accepts the LAST beat; a 1-beat packet yields O one cycle after I_VALID is presented with I_READY=1.
REQ-020 O, O_BEATS and O_VALID are held stable while O_VALID=1 and O_READY=0.
REQ-021 O_VALID clears on an edge with O_VALID=1 and O_READY=1 unless a new LAST beat is accepted on that edge.
REQ-022 I_READY = !O_VALID | O_READY (combinational); input stalls entirely while an unconsumed result is held.
REQ-023 Simultaneous consume and LAST accept: O/O_BEATS take the new packet's values, O_VALID stays 1, no bubble.
REQ-024 Non-LAST beats are accepted while O_VALID=1 only if O_READY=1, per REQ-022.
REQ-025 O_BEATS saturates at 255; ACC keeps accumulating beyond 255 beats.

Reset
REQ-026 With RESETN=0 at an edge: O=0, O_VALID=0, O_BEATS=0, ACC=0, count=0, first-beat state armed, held MODE=00.
REQ-027 Reset mid-packet discards the partial packet; no result is emitted for it.
REQ-028 I_READY=1 in the first cycle after reset is released.

Verification (WIDTH=2, N=3; operands listed op0,op1,op2)
REQ-029 1-beat AND: 11,01,11, LAST=1, MODE=00, O_READY=1 -> next cycle O=01, O_VALID=1, O_BEATS=1; cleared the following cycle.
REQ-030 3-beat XOR: beats (01,00,00),(10,00,00),(01,00,00), LAST on beat 3 -> O=10, O_BEATS=3.
REQ-031 NAND with MODE switched to 01 after beat 1: beats (11,11,11),(11,10,11) LAST -> O=01, O_BEATS=2.
REQ-032 Backpressure: O_READY=0 after result A -> I_READY=0, O stays A; raise O_READY with pending LAST beat B -> O=B same edge, O_VALID stays 1.
REQ-033 Reset mid-packet: 2 OR beats, RESETN=0 one cycle, then 1-beat OR packet (01,00,00) LAST -> O=01, O_BEATS=1.
REQ-034 300-beat AND packet of all-ones operands -> O=11, O_BEATS=255.
